axi4_burst_ram: RTL and testbench
=================================

Name: axi4_burst_ram

Overview:
- AXI4 slave memory used as simulation main RAM behind the SoC core's 64-bit AXI RAM port.
- Independent read and write channel engines implement FIXED, INCR and WRAP bursts with byte strobes.
- Storage is a plain array named mem, so benches can backdoor-load it with $readmemh.
- Always responds OKAY.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, byte-address width; memory size is 2**ADDR_WIDTH bytes.
- ID_WIDTH, 6, width of AWID/BID/ARID/RID.
- STRB_WIDTH, DATA_WIDTH/8, strobe width; derived, do not override.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: reset, asynchronous, active-high.
- s_axi_awid in ID_WIDTH; s_axi_awaddr in ADDR_WIDTH; s_axi_awlen in 8; s_axi_awsize in 3; s_axi_awburst in 2: write address channel.
- s_axi_awlock in 1; s_axi_awcache in 4; s_axi_awprot in 3: accepted and ignored.
- s_axi_awvalid in 1; s_axi_awready out 1: write address handshake.
- s_axi_wdata in DATA_WIDTH; s_axi_wstrb in STRB_WIDTH; s_axi_wlast in 1; s_axi_wvalid in 1; s_axi_wready out 1: write data channel.
- s_axi_bid out ID_WIDTH; s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1: write response channel.
- s_axi_arid in ID_WIDTH; s_axi_araddr in ADDR_WIDTH; s_axi_arlen in 8; s_axi_arsize in 3; s_axi_arburst in 2: read address channel.
- s_axi_arlock in 1; s_axi_arcache in 4; s_axi_arprot in 3: accepted and ignored.
- s_axi_arvalid in 1; s_axi_arready out 1: read address handshake.
- s_axi_rid out ID_WIDTH; s_axi_rdata out DATA_WIDTH; s_axi_rresp out 2; s_axi_rlast out 1; s_axi_rvalid out 1; s_axi_rready in 1: read data channel.

Behaviour:
- Storage: mem[0 : 2**(ADDR_WIDTH-log2(STRB_WIDTH))-1], DATA_WIDTH bits wide. Word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]. mem is not cleared by reset.
- Reset: all outputs registered and reset to 0 (awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, ids, rdata). First cycle after reset release: awready=arready=1.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid&awready, capture id, addr, len, size, burst; go to W_DATA with wready=1 next cycle.
  - W_DATA: each wvalid&wready beat writes byte lanes where wstrb[i]=1 into mem[word(addr)], then advances addr.
  - On the beat with count==len: wready drops, go to W_RESP with bvalid=1, bid=captured id, bresp=00. wlast is not used for termination; beat count rules.
  - W_RESP: hold bvalid until bready. Then W_IDLE with awready=1 next cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, capture fields; next cycle rvalid=1 with rdata=mem[word(araddr)], rid=arid, rresp=00, rlast=(len==0).
  - R_DATA: on rvalid&rready, advance addr; the next beat is presented in the following cycle with no bubble (rvalid stays 1).
  - While rready=0: rdata, rlast, rid held stable.
  - After the last beat (rlast&rready): rvalid=0, arready=1 next cycle.
- Address advance, with bytes=1<<size:
  - FIXED (00): address unchanged.
  - INCR (01): addr+=bytes, wrapping modulo 2**ADDR_WIDTH.
  - WRAP (10): boundary = bytes*(len+1), legal len 1/3/7/15. addr = (addr & ~(boundary-1)) | ((addr+bytes) & (boundary-1)).
  - Reserved (11): treated as INCR.
- Narrow transfers (size<log2 STRB): master supplies correct lanes and strobes; RAM writes per-strobe and always returns the full word on reads.
- Read and write channels run concurrently. Same-cycle read and write to the same word: read returns old data, write takes effect after.
- Reset asserted mid-burst: both FSMs go to IDLE immediately. Burst abandoned; bytes already written remain in mem.

Decomposition:
- Shared package axi_pkg: burst-type constants (BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10) and RESP_OKAY=2'b00.
- One sub-module, axi_burst_addr_next: combinational next-address for (addr, size, len, burst), instanced once per channel.

Test Plan:
- Single beat: write 0x1122334455667788 to 0x0040 with wstrb=0xFF, id=5 -> bvalid with bid=5, bresp=0. Read 0x0040 len=0 -> rdata=0x1122334455667788, rlast=1, rid=5.
- INCR: len=7, size=3 at 0x0100, data 0..7 -> reads back 0..7 in order; rlast only on beat 7.
- Strobes: write 0xFFFF... to 0x0200 with wstrb=0x0F onto a zeroed word -> read 0x00000000FFFFFFFF.
- WRAP: len=3, size=3 read starting 0x0310 -> words fetched from 0x0310, 0x0318, 0x0300, 0x0308. FIXED len=3 read -> same word four times.
- Backpressure: rready toggling 1-0-1 during an 8-beat read -> no beat lost or duplicated, data stable while stalled. bready held low 5 cycles -> bvalid held and awready stays 0.
- Backdoor and reset: $readmemh into mem, then a read returns the file contents. rst asserted mid write burst -> bvalid, rvalid, wready go 0 at once; awready=1 the cycle after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings for the burst RAM and its address helper.
//   BURST_FIXED / BURST_INCR / BURST_WRAP : AxBURST encodings (2'b11 is reserved)
//   RESP_OKAY                             : BRESP/RRESP value for a successful transfer
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

endpackage

// File: rtl/axi_burst_addr_next.sv
// Combinational next-beat address for an AXI4 burst.
// Ports:
//   addr      : current beat byte address
//   size      : AxSIZE, bytes per beat = 1 << size
//   len       : AxLEN, beats - 1 (defines the wrap boundary)
//   burst     : AxBURST; reserved encoding behaves as INCR
//   addr_next : address of the following beat
module axi_burst_addr_next
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] addr_next
);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size;
    incr      = addr + bytes;
    // Wrap boundary is the total burst size; legal WRAP lengths make it a power of two.
    wrap_mask = (bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1))) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: addr_next = addr;
      BURST_WRAP:  addr_next = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     addr_next = incr;
    endcase
  end

endmodule

// File: rtl/axi4_burst_ram.sv
// AXI4 slave simulation RAM with independent read and write burst engines.
// Ports:
//   clk, rst            : clock (rising edge) and asynchronous active-high reset
//   s_axi_aw*           : write address channel (lock/cache/prot ignored)
//   s_axi_w*            : write data channel with byte strobes (wlast ignored, beat count ends burst)
//   s_axi_b*            : write response channel, always OKAY
//   s_axi_ar*           : read address channel (lock/cache/prot ignored)
//   s_axi_r*            : read data channel, always OKAY, full word returned
// Storage lives in the plain array mem so it can be backdoor-loaded; reset does not clear it.
module axi4_burst_ram
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 6,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int WordLsb  = $clog2(STRB_WIDTH);
  localparam int IdxW     = ADDR_WIDTH - WordLsb;
  localparam int MemWords = 2 ** IdxW;

  logic [DATA_WIDTH-1:0] mem [0:MemWords-1];

  function automatic logic [IdxW-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:WordLsb];
  endfunction

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d, bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, waddr_next;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  mem_we;

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_next;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot};

  axi_burst_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr_next (
    .addr(waddr_q), .size(wsize_q), .len(wlen_q), .burst(wburst_q), .addr_next(waddr_next)
  );

  axi_burst_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr_next (
    .addr(raddr_q), .size(rsize_q), .len(rlen_q), .burst(rburst_q), .addr_next(raddr_next)
  );

  // Write engine next state
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    mem_we    = 1'b0;
    case (w_state_q)
      WIdle: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          wid_d     = s_axi_awid;
          waddr_d   = s_axi_awaddr;
          wlen_d    = s_axi_awlen;
          wsize_d   = s_axi_awsize;
          wburst_d  = s_axi_awburst;
          wcnt_d    = '0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = WData;
        end
      end
      WData: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we  = 1'b1;
          waddr_d = waddr_next;
          wcnt_d  = wcnt_q + 8'd1;
          if (wcnt_q == wlen_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = wid_q;
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read engine next state; the next beat's data is fetched on acceptance so there is no bubble.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    case (r_state_q)
      RIdle: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = s_axi_arid;
          rdata_d   = mem[word_of(s_axi_araddr)];
          rlast_d   = (s_axi_arlen == 8'd0);
          raddr_d   = s_axi_araddr;
          rlen_d    = s_axi_arlen;
          rsize_d   = s_axi_arsize;
          rburst_d  = s_axi_arburst;
          rcnt_d    = '0;
          r_state_d = RData;
        end
      end
      RData: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = RIdle;
          end else begin
            raddr_d = raddr_next;
            rdata_d = mem[word_of(raddr_next)];
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= WIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // Byte-lane writes; a same-cycle read of this word sees the old contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[word_of(waddr_q)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi4_burst_ram.sv
module tb_axi4_burst_ram;

  logic        clk, rst;
  logic [5:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [15:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [2:0]  s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awlock, s_axi_arlock;
  logic [3:0]  s_axi_awcache, s_axi_arcache;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [63:0] s_axi_wdata, s_axi_rdata;

  axi4_burst_ram dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference memory: one 64-bit word per 8-byte address
  logic [63:0] ref_mem [0:8191];
  logic [63:0] wd_q [$];
  logic [7:0]  ws_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i of a burst, computed directly from the burst definition.
  function automatic int beat_addr(input int addr, input int i, input int size, input int len,
                                   input int burst);
    int bytes, bnd, base;
    bytes = 1 << size;
    if (burst == 0) return addr;
    if (burst == 2) begin
      bnd  = bytes * (len + 1);
      base = addr - (addr % bnd);
      return base + ((addr - base + i * bytes) % bnd);
    end
    return (addr + i * bytes) % 65536;
  endfunction

  task automatic model_write(input int a, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++) if (s[b]) ref_mem[a >> 3][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic aw_send(input int id, input int addr, input int len, input int size,
                         input int burst);
    int n;
    s_axi_awid = 6'(id); s_axi_awaddr = 16'(addr); s_axi_awlen = 8'(len);
    s_axi_awsize = 3'(size); s_axi_awburst = 2'(burst); s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(posedge clk); #1; n++; end
    check("aw_handshake_in_time", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  // Sends beat i of the queued write data; returns after the accepting edge.
  task automatic w_beat(input int i, input int addr, input int len, input int size,
                        input int burst);
    int n;
    s_axi_wdata = wd_q[i]; s_axi_wstrb = ws_q[i]; s_axi_wlast = (i == len); s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_wready && n < 50) begin @(posedge clk); #1; n++; end
    check("w_handshake_in_time", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    model_write(beat_addr(addr, i, size, len, burst), wd_q[i], ws_q[i]);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic axi_write(input int id, input int addr, input int len, input int size,
                           input int burst, input int bdelay);
    aw_send(id, addr, len, size, burst);
    for (int i = 0; i <= len; i++) w_beat(i, addr, len, size, burst);
    check("bvalid_after_last", 64'(s_axi_bvalid), 64'd1);
    check("bid", 64'(s_axi_bid), 64'(id));
    check("bresp", 64'(s_axi_bresp), 64'd0);
    check("wready_after_last", 64'(s_axi_wready), 64'd0);
    for (int d = 0; d < bdelay; d++) begin
      @(posedge clk); #1;
      check("bvalid_held", 64'(s_axi_bvalid), 64'd1);
      check("awready_low_in_resp", 64'(s_axi_awready), 64'd0);
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check("bvalid_cleared", 64'(s_axi_bvalid), 64'd0);
    check("awready_after_resp", 64'(s_axi_awready), 64'd1);
  endtask

  // mode 0: rready always high, 1: random rready, 2: rready toggles each cycle
  task automatic axi_read(input int id, input int addr, input int len, input int size,
                          input int burst, input int mode);
    int n, beat;
    logic        held_v, held_l;
    logic [63:0] held_d;
    s_axi_arid = 6'(id); s_axi_araddr = 16'(addr); s_axi_arlen = 8'(len);
    s_axi_arsize = 3'(size); s_axi_arburst = 2'(burst); s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(posedge clk); #1; n++; end
    check("ar_handshake_in_time", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    beat = 0; n = 0; held_v = 1'b0; held_d = '0; held_l = 1'b0;
    while (beat <= len && n < 1000) begin
      case (mode)
        1:       s_axi_rready = ($urandom_range(0, 1) == 1);
        2:       s_axi_rready = (n % 2 == 0);
        default: s_axi_rready = 1'b1;
      endcase
      if (held_v) begin
        check("rdata_stable_in_stall", s_axi_rdata, held_d);
        check("rlast_stable_in_stall", 64'(s_axi_rlast), 64'(held_l));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        check("rdata", s_axi_rdata, ref_mem[beat_addr(addr, beat, size, len, burst) >> 3]);
        check("rlast", 64'(s_axi_rlast), 64'(beat == len));
        check("rid", 64'(s_axi_rid), 64'(id));
        check("rresp", 64'(s_axi_rresp), 64'd0);
        beat++;
      end
      held_v = s_axi_rvalid && !s_axi_rready;
      held_d = s_axi_rdata;
      held_l = s_axi_rlast;
      @(posedge clk); #1;
      n++;
    end
    s_axi_rready = 1'b0;
    check("read_beat_count", 64'(beat), 64'(len + 1));
    check("rvalid_after_burst", 64'(s_axi_rvalid), 64'd0);
    check("arready_after_burst", 64'(s_axi_arready), 64'd1);
  endtask

  task automatic fill(input int len, input bit rnd, input logic [7:0] strb);
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i <= len; i++) begin
      wd_q.push_back(rnd ? {$urandom, $urandom} : 64'(i));
      ws_q.push_back(strb);
    end
  endtask

  initial begin
    int burst, size, len, addr;
    logic [3:0] wlens;
    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_arid = '0; s_axi_araddr = '0;
    s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arlock = 1'b0;
    s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      dut.mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(s_axi_awready), 64'd0);
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_rlast", 64'(s_axi_rlast), 64'd0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    check("rst_wready", 64'(s_axi_wready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("awready_after_release", 64'(s_axi_awready), 64'd1);
    check("arready_after_release", 64'(s_axi_arready), 64'd1);

    // Single beat write and read back
    wd_q.delete(); ws_q.delete();
    wd_q.push_back(64'h1122334455667788); ws_q.push_back(8'hFF);
    axi_write(5, 16'h0040, 0, 3, 1, 0);
    axi_read(5, 16'h0040, 0, 3, 1, 0);
    check("single_beat_value", ref_mem[16'h0040 >> 3], 64'h1122334455667788);

    // INCR 8 beats of 0..7
    fill(7, 1'b0, 8'hFF);
    axi_write(1, 16'h0100, 7, 3, 1, 0);
    axi_read(2, 16'h0100, 7, 3, 1, 0);

    // Partial strobes onto a zeroed word
    fill(0, 1'b1, 8'h0F);
    wd_q[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(3, 16'h0200, 0, 3, 1, 0);
    axi_read(3, 16'h0200, 0, 3, 1, 0);

    // WRAP and FIXED reads over distinct data
    fill(3, 1'b1, 8'hFF);
    axi_write(4, 16'h0300, 3, 3, 1, 0);
    axi_read(6, 16'h0310, 3, 3, 2, 0);
    axi_read(7, 16'h0308, 3, 3, 0, 0);

    // Back-pressure on both response and read data
    fill(7, 1'b1, 8'hFF);
    axi_write(9, 16'h0400, 7, 3, 1, 5);
    axi_read(10, 16'h0400, 7, 3, 1, 2);

    // Randomised bursts of all types and sizes
    for (int t = 0; t < 14; t++) begin
      burst = $urandom_range(0, 3);
      size  = $urandom_range(0, 3);
      wlens = 4'($urandom_range(0, 15));
      len   = (burst == 2) ? (1 << $urandom_range(1, 4)) - 1 : int'(wlens);
      addr  = $urandom_range(0, 65535) & ~((1 << size) - 1);
      wd_q.delete(); ws_q.delete();
      for (int i = 0; i <= len; i++) begin
        wd_q.push_back({$urandom, $urandom});
        ws_q.push_back(8'($urandom));
      end
      axi_write($urandom_range(0, 63), addr, len, size, burst, $urandom_range(0, 2));
      axi_read($urandom_range(0, 63), addr, len, size, burst, 1);
    end

    // Backdoor load then read
    for (int i = 0; i < 16; i++) begin
      ref_mem[16'h0800 + i] = {$urandom, $urandom};
      dut.mem[16'h0800 + i] = ref_mem[16'h0800 + i];
    end
    axi_read(11, 16'h4000, 15, 3, 1, 0);

    // Reset in the middle of a write burst, with a write beat still offered
    fill(7, 1'b1, 8'hFF);
    aw_send(12, 16'h0600, 7, 3, 1);
    for (int i = 0; i < 3; i++) w_beat(i, 16'h0600, 7, 3, 1);
    s_axi_wdata = wd_q[3]; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_wready", 64'(s_axi_wready), 64'd0);
    check("midrst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("midrst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("midrst_awready", 64'(s_axi_awready), 64'd0);
    s_axi_wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("awready_after_midrst", 64'(s_axi_awready), 64'd1);
    check("arready_after_midrst", 64'(s_axi_arready), 64'd1);
    axi_read(13, 16'h0600, 7, 3, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
